// File: rtl/mux_arbiter.sv
// ============================================================================
//  Module   : mux_arbiter
//  Purpose  : Two-requester arbiter sharing one WIDTH-bit data path between
//             requester A and requester B. A registered grant state machine
//             owns the 2:1 word selector. Ties are resolved round-robin and
//             a hold limit stops a contended owner from starving the other.
//  Ports    : CLK            clock, all state changes on the rising edge
//             RESET          synchronous, active-high reset
//             REQ_A, REQ_B   requests, held high for the whole transfer
//             A, B           requester data words
//             GNT_A, GNT_B   registered grants (never both high)
//             SEL            registered select, 0 = A, 1 = B
//             OUT            SEL ? B : A (combinational from SEL)
//             VALID          GNT_A | GNT_B, OUT carries owned data
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_arbiter #(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ_A,
  input  logic             REQ_B,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             GNT_A,
  output logic             GNT_B,
  output logic             SEL,
  output logic [WIDTH-1:0] OUT,
  output logic             VALID
);

  // Hold counter must represent 0..MAX_HOLD; keep at least one bit so the
  // unlimited (MAX_HOLD = 0) build still has a legal vector.
  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  localparam logic [CNT_W-1:0] c_HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

  // r_last encoding: which side was served most recently
  localparam logic c_SIDE_A = 1'b0;
  localparam logic c_SIDE_B = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN_A = 2'd1,
    S_OWN_B = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last;
  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_gnt_a;
  logic             r_gnt_b;
  logic             r_sel;

  // The current owner has used up its allowance: this is its last cycle if
  // the other side is still waiting.
  logic w_hold_expired;
  logic [CNT_W-1:0] w_hold_next;

  assign w_hold_expired = (MAX_HOLD != 0) && (r_hold_cnt == c_HOLD_LAST);
  assign w_hold_next    = (r_hold_cnt == c_HOLD_MAX) ? r_hold_cnt : r_hold_cnt + 1'b1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_last     <= c_SIDE_B;   // A wins the first tie
      r_hold_cnt <= '0;
      r_gnt_a    <= 1'b0;
      r_gnt_b    <= 1'b0;
      r_sel      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // SEL is left untouched while idle so OUT keeps showing the
          // most recently selected side.
          if (REQ_A && (!REQ_B || r_last == c_SIDE_B)) begin
            r_state    <= S_OWN_A;
            r_gnt_a    <= 1'b1;
            r_gnt_b    <= 1'b0;
            r_sel      <= 1'b0;
            r_hold_cnt <= '0;
          end else if (REQ_B) begin
            r_state    <= S_OWN_B;
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b1;
            r_sel      <= 1'b1;
            r_hold_cnt <= '0;
          end
        end

        S_OWN_A: begin
          if (!REQ_A || (REQ_B && w_hold_expired)) begin
            r_last <= c_SIDE_A;
            if (REQ_B) begin
              // Direct handoff, no idle bubble between owners
              r_state    <= S_OWN_B;
              r_gnt_a    <= 1'b0;
              r_gnt_b    <= 1'b1;
              r_sel      <= 1'b1;
              r_hold_cnt <= '0;
            end else begin
              r_state    <= S_IDLE;
              r_gnt_a    <= 1'b0;
              r_gnt_b    <= 1'b0;
              r_hold_cnt <= '0;
            end
          end else begin
            r_hold_cnt <= w_hold_next;
          end
        end

        S_OWN_B: begin
          if (!REQ_B || (REQ_A && w_hold_expired)) begin
            r_last <= c_SIDE_B;
            if (REQ_A) begin
              r_state    <= S_OWN_A;
              r_gnt_a    <= 1'b1;
              r_gnt_b    <= 1'b0;
              r_sel      <= 1'b0;
              r_hold_cnt <= '0;
            end else begin
              r_state    <= S_IDLE;
              r_gnt_a    <= 1'b0;
              r_gnt_b    <= 1'b0;
              r_hold_cnt <= '0;
            end
          end else begin
            r_hold_cnt <= w_hold_next;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_gnt_a    <= 1'b0;
          r_gnt_b    <= 1'b0;
          r_hold_cnt <= '0;
        end
      endcase
    end
  end

  assign GNT_A = r_gnt_a;
  assign GNT_B = r_gnt_b;
  assign SEL   = r_sel;
  assign VALID = r_gnt_a | r_gnt_b;
  assign OUT   = r_sel ? B : A;

endmodule

`default_nettype wire

// File: tb/tb_mux_arbiter.sv
// ============================================================================
//  Module   : tb_mux_arbiter
//  Purpose  : Self-checking bench for mux_arbiter. Two instances share one
//             stimulus stream: one with MAX_HOLD = 8 and one with
//             MAX_HOLD = 0 (no preemption). A behavioural model tracks the
//             owner of each instance and is compared every cycle; directed
//             literal checks pin the model to hand-computed values.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux_arbiter;

  localparam int WIDTH = 16;

  logic             CLK;
  logic             RESET;
  logic             REQ_A;
  logic             REQ_B;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;

  logic             GNT_A_8, GNT_B_8, SEL_8, VALID_8;
  logic [WIDTH-1:0] OUT_8;
  logic             GNT_A_0, GNT_B_0, SEL_0, VALID_0;
  logic [WIDTH-1:0] OUT_0;

  int total;
  int bad;

  mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(8)) dut (
    .CLK(CLK), .RESET(RESET), .REQ_A(REQ_A), .REQ_B(REQ_B), .A(A), .B(B),
    .GNT_A(GNT_A_8), .GNT_B(GNT_B_8), .SEL(SEL_8), .OUT(OUT_8), .VALID(VALID_8)
  );

  mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .REQ_A(REQ_A), .REQ_B(REQ_B), .A(A), .B(B),
    .GNT_A(GNT_A_0), .GNT_B(GNT_B_0), .SEL(SEL_0), .OUT(OUT_0), .VALID(VALID_0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: owner is 0 = none, 1 = A, 2 = B. 'held' counts how
  // many cycles the owner has had the path so far (unbounded integer).
  // ---------------------------------------------------------------------
  int m_own  [2];
  int m_last [2];   // 1 = A served last, 2 = B served last
  int m_held [2];
  int m_sel  [2];
  int m_ready;
  int c_MH   [2] = '{8, 0};

  initial m_ready = 0;

  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (RESET) begin
        m_own[k] = 0; m_last[k] = 2; m_held[k] = 0; m_sel[k] = 0;
      end else if (m_own[k] == 0) begin
        if (REQ_A && REQ_B)  m_own[k] = (m_last[k] == 1) ? 2 : 1;
        else if (REQ_A)      m_own[k] = 1;
        else if (REQ_B)      m_own[k] = 2;
        if (m_own[k] != 0) begin
          m_held[k] = 0;
          m_sel[k]  = (m_own[k] == 2) ? 1 : 0;
        end
      end else begin
        int other;
        logic mine, theirs;
        other  = 3 - m_own[k];
        mine   = (m_own[k] == 1) ? REQ_A : REQ_B;
        theirs = (m_own[k] == 1) ? REQ_B : REQ_A;
        // Owner gives up on release, or after MAX_HOLD cycles if contended
        if (!mine || (theirs && c_MH[k] != 0 && m_held[k] + 1 >= c_MH[k])) begin
          m_last[k] = m_own[k];
          if (theirs) begin
            m_own[k]  = other;
            m_held[k] = 0;
            m_sel[k]  = (other == 2) ? 1 : 0;
          end else begin
            m_own[k] = 0;
          end
        end else begin
          m_held[k] = m_held[k] + 1;
        end
      end
    end
    if (RESET) m_ready = 1;
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge CLK) begin
    if (m_ready != 0) begin
      chk("gnt_a_mh8", {31'd0, GNT_A_8}, (m_own[0] == 1) ? 32'd1 : 32'd0);
      chk("gnt_b_mh8", {31'd0, GNT_B_8}, (m_own[0] == 2) ? 32'd1 : 32'd0);
      chk("valid_mh8", {31'd0, VALID_8}, (m_own[0] != 0) ? 32'd1 : 32'd0);
      chk("sel_mh8",   {31'd0, SEL_8},   32'(m_sel[0]));
      chk("out_mh8",   {16'd0, OUT_8},   {16'd0, (m_sel[0] != 0) ? B : A});
      chk("gnt_a_mh0", {31'd0, GNT_A_0}, (m_own[1] == 1) ? 32'd1 : 32'd0);
      chk("gnt_b_mh0", {31'd0, GNT_B_0}, (m_own[1] == 2) ? 32'd1 : 32'd0);
      chk("valid_mh0", {31'd0, VALID_0}, (m_own[1] != 0) ? 32'd1 : 32'd0);
      chk("sel_mh0",   {31'd0, SEL_0},   32'(m_sel[1]));
      chk("out_mh0",   {16'd0, OUT_0},   {16'd0, (m_sel[1] != 0) ? B : A});
      chk("mutex_mh8", {31'd0, GNT_A_8 & GNT_B_8}, 32'd0);
    end
  end

  // Advance one clock; inputs change 1 time unit after the edge
  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RESET = 1'b1; REQ_A = 1'b1; REQ_B = 1'b1;
    A = 16'h1234; B = 16'hBEEF;

    // Reset with both requesting: nothing granted
    cyc(2);
    chk("rst_gnt_a", {31'd0, GNT_A_8}, 32'd0);
    chk("rst_gnt_b", {31'd0, GNT_B_8}, 32'd0);
    chk("rst_sel",   {31'd0, SEL_8},   32'd0);
    chk("rst_valid", {31'd0, VALID_8}, 32'd0);
    chk("rst_out",   {16'd0, OUT_8},   32'h1234);
    RESET = 1'b0;
    cyc(1);
    chk("first_tie_a", {31'd0, GNT_A_8}, 32'd1);
    chk("first_out",   {16'd0, OUT_8},   32'h1234);

    // Release to idle; A was served last
    REQ_A = 1'b0; REQ_B = 1'b0;
    cyc(2);

    // Single requester B held 20 cycles, never preempted
    REQ_B = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("single_gnt_b", {31'd0, GNT_B_8}, 32'd1);
      chk("single_out",   {16'd0, OUT_8},   32'hBEEF);
    end
    REQ_B = 1'b0;
    cyc(1);
    chk("single_idle_valid", {31'd0, VALID_8}, 32'd0);
    chk("single_idle_sel",   {31'd0, SEL_8},   32'd1);
    chk("single_idle_out",   {16'd0, OUT_8},   32'hBEEF);

    // Continuous contention: B was last, so A first; 8/8/8 alternation.
    // The unlimited instance keeps A for all 100 cycles.
    REQ_A = 1'b1; REQ_B = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (i < 24) begin
        chk("alt_gnt_a", {31'd0, GNT_A_8}, ((i / 8) % 2 == 0) ? 32'd1 : 32'd0);
        chk("alt_gnt_b", {31'd0, GNT_B_8}, ((i / 8) % 2 == 1) ? 32'd1 : 32'd0);
      end
      chk("nolimit_gnt_a", {31'd0, GNT_A_0}, 32'd1);
    end
    REQ_A = 1'b0;
    cyc(1);
    chk("nolimit_handoff_b", {31'd0, GNT_B_0}, 32'd1);
    chk("nolimit_handoff_a", {31'd0, GNT_A_0}, 32'd0);
    REQ_B = 1'b0;
    cyc(2);

    // Release handoff: A owns, B raised, A drops after 3 cycles
    REQ_A = 1'b1;
    cyc(1);
    chk("ho_own_a", {31'd0, GNT_A_8}, 32'd1);
    REQ_B = 1'b1;
    cyc(3);
    chk("ho_still_a", {31'd0, GNT_A_8}, 32'd1);
    REQ_A = 1'b0;
    cyc(1);
    chk("ho_gnt_b", {31'd0, GNT_B_8}, 32'd1);
    chk("ho_gnt_a", {31'd0, GNT_A_8}, 32'd0);
    REQ_B = 1'b0;
    cyc(2);

    // A released to idle -> last = A, so the next tie goes to B
    REQ_A = 1'b1;
    cyc(3);
    REQ_A = 1'b0;
    cyc(2);
    REQ_A = 1'b1; REQ_B = 1'b1;
    cyc(1);
    chk("tie_after_a_gnt_b", {31'd0, GNT_B_8}, 32'd1);
    REQ_A = 1'b0; REQ_B = 1'b0;
    cyc(2);

    // Reset mid-grant: B owns 4 cycles, reset, then a tie goes to A
    REQ_B = 1'b1;
    cyc(4);
    chk("mid_own_b", {31'd0, GNT_B_8}, 32'd1);
    REQ_A = 1'b1;
    RESET = 1'b1;
    cyc(1);
    chk("mid_rst_gnt_b", {31'd0, GNT_B_8}, 32'd0);
    chk("mid_rst_valid", {31'd0, VALID_8}, 32'd0);
    chk("mid_rst_sel",   {31'd0, SEL_8},   32'd0);
    RESET = 1'b0;
    cyc(1);
    chk("mid_tie_gnt_a", {31'd0, GNT_A_8}, 32'd1);
    chk("mid_tie_out",   {16'd0, OUT_8},   32'h1234);

    // Preemption after a reset still gives A exactly 8 cycles
    cyc(7);
    chk("post_rst_a8", {31'd0, GNT_A_8}, 32'd1);
    cyc(1);
    chk("post_rst_b",  {31'd0, GNT_B_8}, 32'd1);

    REQ_A = 1'b0; REQ_B = 1'b0;
    cyc(3);
    @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
